// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and widths for the UART transmit arbiter.
package uart_tx_arbiter_pkg;

    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned GRANT_ID_W  = 3;
    localparam int unsigned BURST_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Round-robin pick: first asserted request strictly after ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned N = 4,
    parameter int unsigned W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] gnt_id,
    output logic         any
);

    // Walk from farthest to nearest so the slot right after ptr overrides the rest.
    always_comb begin
        gnt_id = '0;
        any    = 1'b0;
        for (int unsigned i = N; i >= 1; i--) begin
            int unsigned idx;
            idx = (32'(ptr) + i) % N;
            if (req[idx]) begin
                gnt_id = W'(idx);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte producers with round-robin,
// burst-limited grants and a start timeout when the transmitter never goes busy.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned MAX_BURST     = 16,
    parameter int unsigned START_TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [BYTE_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [BYTE_W-1:0]         tx_data,
    output logic                      tx_start,
    input  logic                      tx_busy,
    output logic                      grant_valid,
    output logic [GRANT_ID_W-1:0]     grant_id,
    output logic                      err_timeout
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned TMO_W = $clog2(START_TIMEOUT + 1);

    state_t                 state;
    logic [IDX_W-1:0]       ptr;
    logic [IDX_W-1:0]       grant;
    logic [TMO_W-1:0]       tmo_cnt;
    logic [BURST_CNT_W-1:0] burst_cnt;
    logic                   last_cap;

    logic [IDX_W-1:0]       arb_id;
    logic                   arb_any;
    logic [BYTE_W-1:0]      owner_byte_c;
    logic                   owner_valid_c;
    logic                   owner_last_c;
    logic                   more_c;
    logic                   tmo_hit_c;

    rr_arbiter #(
        .N (NUM_REQ),
        .W (IDX_W)
    ) u_rr (
        .req    (req_valid),
        .ptr    (ptr),
        .gnt_id (arb_id),
        .any    (arb_any)
    );

    // Only the current owner's request lines are looked at during a grant.
    always_comb begin
        owner_byte_c  = req_data[32'(grant) * BYTE_W +: BYTE_W];
        owner_valid_c = req_valid[grant];
        owner_last_c  = req_last[grant];
        more_c        = !last_cap
                        && ((9'(burst_cnt) + 9'd1) < 9'(MAX_BURST))
                        && owner_valid_c;
        tmo_hit_c     = (tmo_cnt == TMO_W'(START_TIMEOUT - 1));
    end

    assign grant_id = GRANT_ID_W'(grant);

    // Grant FSM; a continued burst byte is issued straight from WAIT_DONE so
    // the next strobe follows the busy fall by a single clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            ptr         <= IDX_W'(NUM_REQ - 1);
            grant       <= '0;
            grant_valid <= 1'b0;
            burst_cnt   <= '0;
            tmo_cnt     <= '0;
            last_cap    <= 1'b0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            req_ready   <= '0;
            err_timeout <= 1'b0;
        end else begin
            tx_start    <= 1'b0;
            req_ready   <= '0;
            err_timeout <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        grant       <= arb_id;
                        grant_valid <= 1'b1;
                        burst_cnt   <= '0;
                        state       <= ST_SEND;
                    end
                end

                ST_SEND: begin
                    if (owner_valid_c) begin
                        tx_start  <= 1'b1;
                        tx_data   <= owner_byte_c;
                        req_ready <= NUM_REQ'(1) << grant;
                        last_cap  <= owner_last_c;
                        tmo_cnt   <= '0;
                        state     <= ST_WAIT_BUSY;
                    end else begin
                        ptr         <= grant;
                        grant_valid <= 1'b0;
                        burst_cnt   <= '0;
                        state       <= ST_IDLE;
                    end
                end

                ST_WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= ST_WAIT_DONE;
                    end else if (tmo_hit_c) begin
                        err_timeout <= 1'b1;
                        ptr         <= grant;
                        grant_valid <= 1'b0;
                        burst_cnt   <= '0;
                        state       <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end

                ST_WAIT_DONE: begin
                    if (!tx_busy) begin
                        if (more_c) begin
                            burst_cnt <= burst_cnt + BURST_CNT_W'(1);
                            tx_start  <= 1'b1;
                            tx_data   <= owner_byte_c;
                            req_ready <= NUM_REQ'(1) << grant;
                            last_cap  <= owner_last_c;
                            tmo_cnt   <= '0;
                            state     <= ST_WAIT_BUSY;
                        end else begin
                            ptr         <= grant;
                            grant_valid <= 1'b0;
                            burst_cnt   <= '0;
                            state       <= ST_IDLE;
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a transmitter model, requester queues
// and an expected-transmission scoreboard.
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;

    logic                clk;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [8*NREQ-1:0]   req_data;
    logic [NREQ-1:0]     req_last;
    logic [NREQ-1:0]     req_ready;
    logic [7:0]          tx_data;
    logic                tx_start;
    logic                tx_busy;
    logic                grant_valid;
    logic [2:0]          grant_id;
    logic                err_timeout;

    uart_tx_arbiter #(
        .NUM_REQ       (4),
        .MAX_BURST     (16),
        .START_TIMEOUT (64)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_busy     (tx_busy),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .err_timeout (err_timeout)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       last;
    } rent_t;

    typedef struct packed {
        logic [2:0] id;
        logic [7:0] d;
    } xent_t;

    rent_t rq [NREQ][$];
    xent_t exp_q [$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int tx_count = 0;
    int rise_cyc = 0;
    int last_lat = 0;
    int last_start_cyc = 0;
    int fall_cyc = 0;
    int busy_cnt = 0;
    logic busy_pend = 1'b0;
    logic tx_dead = 1'b0;
    int err_cnt = 0;
    int err_gap = 0;
    logic cont_track = 1'b0;
    int prev_owner = -1;
    int cont_max = 0;
    int cont_n = 0;
    int g2_rel = 99;
    logic gv_prev = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void update_reqs();
        logic [NREQ-1:0] v;
        rent_t           e;
        v        = '0;
        req_data = '0;
        req_last = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (rq[i].size() > 0) begin
                e                = rq[i][0];
                v[i]             = 1'b1;
                req_data[i*8 +: 8] = e.d;
                req_last[i]      = e.last;
            end
        end
        if (req_valid == '0 && v != '0) rise_cyc = cyc;
        req_valid = v;
    endfunction

    function automatic void push(input int id, input logic [7:0] d, input logic last, input logic expect_tx);
        rent_t r;
        xent_t x;
        r.d    = d;
        r.last = last;
        rq[id].push_back(r);
        if (expect_tx) begin
            x.id = 3'(id);
            x.d  = d;
            exp_q.push_back(x);
        end
        update_reqs();
    endfunction

    function automatic void expect_tx(input int id, input logic [7:0] d);
        xent_t x;
        x.id = 3'(id);
        x.d  = d;
        exp_q.push_back(x);
    endfunction

    function automatic logic quiet();
        logic q;
        q = (exp_q.size() == 0) && !grant_valid && !tx_busy && !busy_pend && !rst;
        for (int i = 0; i < NREQ; i++) if (rq[i].size() != 0) q = 1'b0;
        return q;
    endfunction

    // One clock: observe DUT outputs, advance requesters and transmitter model.
    task automatic tick();
        xent_t x;
        rent_t r;
        @(negedge clk);
        cyc++;
        if (tx_start) begin
            chk("start_while_busy", 32'(tx_busy), 32'd0);
            tx_count++;
            if (exp_q.size() == 0) begin
                chk("start_without_expect", 32'({grant_id, tx_data}), 32'hFFFF_FFFF);
            end else begin
                x = exp_q.pop_front();
                chk("sb_grant_id", 32'(grant_id), 32'(x.id));
                chk("sb_tx_data", 32'(tx_data), 32'(x.d));
                chk("sb_req_ready", 32'(req_ready), 32'(4'(1) << x.id));
                chk("sb_grant_valid", 32'(grant_valid), 32'd1);
            end
            last_lat = cyc - rise_cyc;
            if (cont_track && prev_owner == int'(grant_id)) begin
                cont_n++;
                if (cyc - fall_cyc > cont_max) cont_max = cyc - fall_cyc;
            end
            prev_owner     = int'(grant_id);
            last_start_cyc = cyc;
        end
        if (req_ready != '0) chk("ready_only_with_start", 32'(tx_start), 32'd1);
        if (err_timeout) begin
            err_cnt++;
            err_gap = cyc - last_start_cyc;
            chk("release_on_timeout", 32'(grant_valid), 32'd0);
        end
        if (grant_valid && !gv_prev && grant_id == 3'd2) g2_rel = cyc - fall_cyc;
        gv_prev = grant_valid;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i] && rq[i].size() > 0) r = rq[i].pop_front();
        end
        if (rst) begin
            tx_busy   = 1'b0;
            busy_pend = 1'b0;
            busy_cnt  = 0;
        end else begin
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    tx_busy  = 1'b0;
                    fall_cyc = cyc;
                end
            end
            if (busy_pend) begin
                tx_busy   = 1'b1;
                busy_cnt  = 10;
                busy_pend = 1'b0;
            end
            if (tx_start && !tx_dead) busy_pend = 1'b1;
        end
        update_reqs();
    endtask

    task automatic wait_quiet(input string tag, input int budget);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!quiet() && n < budget);
        chk(tag, 32'(quiet()), 32'd1);
        repeat (2) tick();
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        int n;
        int base;
        rst       = 1'b1;
        tx_busy   = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        repeat (3) tick();
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_grant_valid", 32'(grant_valid), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_err_timeout", 32'(err_timeout), 32'd0);
        rst = 1'b0;
        tick();

        // 1: single byte from requester 0
        base = tx_count;
        push(0, 8'h41, 1'b1, 1'b1);
        wait_quiet("t1_settle", 500);
        chk("t1_tx_count", 32'(tx_count - base), 32'd1);
        chk("t1_latency", 32'(last_lat), 32'd2);
        chk("t1_released", 32'(grant_valid), 32'd0);

        // 2: all four requesting single-byte bursts
        pulse_reset();
        base = tx_count;
        push(0, 8'hA0, 1'b1, 1'b1);
        push(1, 8'hA1, 1'b1, 1'b1);
        push(2, 8'hA2, 1'b1, 1'b1);
        push(3, 8'hA3, 1'b1, 1'b1);
        push(0, 8'hA4, 1'b1, 1'b1);
        wait_quiet("t2_settle", 1000);
        chk("t2_tx_count", 32'(tx_count - base), 32'd5);

        // 3: requester 0 streams 20 bytes, requester 1 waits behind the burst cap
        cont_track = 1'b1;
        prev_owner = -1;
        cont_max   = 0;
        cont_n     = 0;
        base       = tx_count;
        for (int k = 0; k < 20; k++) push(0, 8'(8'h10 + k), 1'b0, (k < 16));
        n = 0;
        while (tx_count == base && n < 100) begin
            tick();
            n++;
        end
        chk("t3_first_start", 32'(tx_count - base), 32'd1);
        push(1, 8'hB1, 1'b1, 1'b1);
        for (int k = 16; k < 20; k++) expect_tx(0, 8'(8'h10 + k));
        wait_quiet("t3_settle", 2000);
        chk("t3_tx_count", 32'(tx_count - base), 32'd21);
        chk("t3_burst_gap", 32'(cont_max), 32'd1);
        chk("t3_burst_links", 32'(cont_n), 32'd18);
        cont_track = 1'b0;

        // 4: transmitter never goes busy
        tx_dead = 1'b1;
        push(1, 8'h55, 1'b1, 1'b1);
        n = 0;
        while (err_cnt == 0 && n < 200) begin
            tick();
            n++;
        end
        chk("t4_err_count", 32'(err_cnt), 32'd1);
        chk("t4_err_delay", 32'(err_gap), 32'd64);
        tx_dead = 1'b0;
        wait_quiet("t4_settle_a", 200);
        push(2, 8'hC2, 1'b1, 1'b1);
        push(0, 8'hC0, 1'b1, 1'b1);
        wait_quiet("t4_settle_b", 500);
        chk("t4_err_single", 32'(err_cnt), 32'd1);

        // 5: reset while waiting for the second byte of a burst to finish
        base = tx_count;
        push(0, 8'hD0, 1'b0, 1'b1);
        push(0, 8'hD1, 1'b0, 1'b1);
        push(0, 8'hD2, 1'b1, 1'b0);
        n = 0;
        while (!(tx_count - base >= 2 && tx_busy) && n < 200) begin
            tick();
            n++;
        end
        chk("t5_reached_wait", 32'(tx_count - base), 32'd2);
        repeat (2) tick();
        for (int i = 0; i < NREQ; i++) rq[i].delete();
        rst = 1'b1;
        update_reqs();
        tick();
        chk("t5_tx_start", 32'(tx_start), 32'd0);
        chk("t5_req_ready", 32'(req_ready), 32'd0);
        chk("t5_tx_data", 32'(tx_data), 32'd0);
        chk("t5_grant_valid", 32'(grant_valid), 32'd0);
        chk("t5_grant_id", 32'(grant_id), 32'd0);
        chk("t5_err_timeout", 32'(err_timeout), 32'd0);
        rst = 1'b0;
        tick();
        push(0, 8'hE0, 1'b1, 1'b1);
        push(3, 8'hE3, 1'b1, 1'b1);
        wait_quiet("t5_settle", 500);

        // 6: requester 0 runs dry mid-burst while requester 2 waits
        g2_rel = 99;
        base   = tx_count;
        push(0, 8'hF0, 1'b0, 1'b1);
        push(0, 8'hF1, 1'b0, 1'b1);
        push(0, 8'hF2, 1'b0, 1'b1);
        push(2, 8'hF8, 1'b1, 1'b1);
        wait_quiet("t6_settle", 1000);
        chk("t6_tx_count", 32'(tx_count - base), 32'd4);
        chk("t6_regrant_within_2", 32'(g2_rel <= 2), 32'd1);

        chk("final_err_count", 32'(err_cnt), 32'd1);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
